// File: rtl/mem_sequencer.sv
// Fetch / load-store sequencer letting a single-cycle RV32 core share one single-port memory.
// Optional MEM_SEQ_PERF_EN adds cycle_cnt / instret_cnt performance counters.
module mem_sequencer #(
  parameter int unsigned MAX_WAIT    = 255,
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic [31:0] Instr,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteMask,
  input  logic        MemWrite,
  input  logic        MemStrobe,
  output logic [31:0] ReadData,
  output logic        PCReady,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
`ifdef MEM_SEQ_PERF_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
`endif
  output logic        bus_err
);

  typedef enum logic [1:0] {FETCH, EXEC, COMMIT, ERR} state_t;

  state_t      state_q;
  logic [31:0] instr_q;
  logic [31:0] rdata_q;
  logic [15:0] wait_q;

  logic fetch_req;
  logic data_req;
  logic stall;
  logic timeout;
  logic unused_addr_bits;

  // Byte lane selection of DataAdr is done inside the core.
  assign unused_addr_bits = ^DataAdr[1:0];

  assign fetch_req = (state_q == FETCH) && (PC[1:0] == 2'b00);
  assign data_req  = (state_q == EXEC) && MemStrobe;

  assign mem_req   = !reset && (fetch_req || data_req);
  assign mem_we    = data_req && MemWrite;
  assign mem_addr  = data_req ? {DataAdr[31:2], 2'b00} : {PC[31:2], 2'b00};
  assign mem_wdata = mem_we ? WriteData : 32'h0;
  assign mem_wmask = mem_we ? ByteMask : 4'b0000;

  assign PCReady   = !reset && (((state_q == EXEC) && !MemStrobe) || (state_q == COMMIT));
  assign bus_err   = (state_q == ERR);
  assign Instr     = instr_q;
  assign ReadData  = rdata_q;

  assign stall   = mem_req && !mem_ack;
  // The MAX_WAIT-th unacknowledged cycle is the last one tolerated.
  assign timeout = stall && (wait_q == 16'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      instr_q <= RESET_INSTR;
      rdata_q <= 32'h0;
      wait_q  <= 16'h0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (PC[1:0] != 2'b00) begin
            state_q <= ERR;
            wait_q  <= 16'h0;
          end else if (mem_ack) begin
            instr_q <= mem_rdata;
            state_q <= EXEC;
            wait_q  <= 16'h0;
          end else if (timeout) begin
            state_q <= ERR;
            wait_q  <= 16'h0;
          end else begin
            wait_q  <= wait_q + 16'h1;
          end
        end
        EXEC: begin
          if (!MemStrobe) begin
            state_q <= FETCH;
            wait_q  <= 16'h0;
          end else if (mem_ack) begin
            if (!MemWrite) rdata_q <= mem_rdata;
            state_q <= COMMIT;
            wait_q  <= 16'h0;
          end else if (timeout) begin
            state_q <= ERR;
            wait_q  <= 16'h0;
          end else begin
            wait_q  <= wait_q + 16'h1;
          end
        end
        COMMIT: begin
          state_q <= FETCH;
          wait_q  <= 16'h0;
        end
        default: begin
          state_q <= ERR;
          wait_q  <= 16'h0;
        end
      endcase
    end
  end

`ifdef MEM_SEQ_PERF_EN
  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= 32'h0;
      instret_q <= 32'h0;
    end else if (state_q != ERR) begin
      cycle_q <= cycle_q + 32'h1;
      if (PCReady) instret_q <= instret_q + 32'h1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed self-checking bench for mem_sequencer (MAX_WAIT=4); perf checks need MEM_SEQ_PERF_EN.
`timescale 1ns/1ps
module tb_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [3:0]  ByteMask;
  logic        MemWrite;
  logic        MemStrobe;
  logic [31:0] ReadData;
  logic        PCReady;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;
`ifdef MEM_SEQ_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_sequencer #(.MAX_WAIT(4), .RESET_INSTR(32'h00000013)) dut (
    .clk(clk), .reset(reset), .PC(PC), .Instr(Instr), .DataAdr(DataAdr),
    .WriteData(WriteData), .ByteMask(ByteMask), .MemWrite(MemWrite),
    .MemStrobe(MemStrobe), .ReadData(ReadData), .PCReady(PCReady),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
`ifdef MEM_SEQ_PERF_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .bus_err(bus_err)
  );

  // Advance one clock edge; inputs are driven and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ack = 1'b0; MemStrobe = 1'b0; MemWrite = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; PC = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    MemStrobe = 1'b0; MemWrite = 1'b0; DataAdr = 32'h0; WriteData = 32'h0; ByteMask = 4'h0;
    #1;
    total++; if (mem_req !== 1'b0) $display("FAIL reset_no_req: got %b want 0", mem_req); else passed++;
    step();
    step();
    total++; if (mem_req !== 1'b0) $display("FAIL reset_hold_no_req: got %b want 0", mem_req); else passed++;
    reset = 1'b0; #1;
    total++; if (Instr !== 32'h00000013) $display("FAIL reset_instr: got %h want 00000013", Instr); else passed++;
    total++; if (ReadData !== 32'h0) $display("FAIL reset_rdata: got %h want 0", ReadData); else passed++;
    total++; if (PCReady !== 1'b0 || bus_err !== 1'b0) $display("FAIL reset_flags: got pcready=%b bus_err=%b want 0 0", PCReady, bus_err); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'h00500113; #1;
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0) $display("FAIL fetch0_req: got req=%b we=%b addr=%h want 1 0 0", mem_req, mem_we, mem_addr); else passed++;
    step();
    total++; if (Instr !== 32'h00500113) $display("FAIL exec0_instr: got %h want 00500113", Instr); else passed++;
    total++; if (PCReady !== 1'b1 || mem_req !== 1'b0) $display("FAIL exec0_retire: got pcready=%b req=%b want 1 0", PCReady, mem_req); else passed++;
    mem_ack = 1'b0;
    step();
    total++; if (PCReady !== 1'b0) $display("FAIL fetch1_pcready: got %b want 0", PCReady); else passed++;
    $display("txn addi: Instr=%h", Instr);
  endtask

  task automatic test_load();
    PC = 32'h4; mem_ack = 1'b1; mem_rdata = 32'h06402183; #1;
    step();
    mem_ack = 1'b0; MemStrobe = 1'b1; MemWrite = 1'b0; DataAdr = 32'h64; mem_rdata = 32'hFFFF_FFFF; #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h64 || mem_we !== 1'b0 || mem_wmask !== 4'b0000)
        $display("FAIL lw_wait%0d: got req=%b addr=%h we=%b mask=%b want 1 64 0 0000", i, mem_req, mem_addr, mem_we, mem_wmask);
      else passed++;
      total++; if (PCReady !== 1'b0 || Instr !== 32'h06402183 || ReadData !== 32'h0)
        $display("FAIL lw_hold%0d: got pcready=%b instr=%h rdata=%h want 0 06402183 0", i, PCReady, Instr, ReadData);
      else passed++;
      step();
    end
    mem_ack = 1'b1; mem_rdata = 32'h19; #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h64) $display("FAIL lw_ack_cycle: got req=%b addr=%h want 1 64", mem_req, mem_addr); else passed++;
    step();
    mem_ack = 1'b0; #1;
    total++; if (PCReady !== 1'b1 || ReadData !== 32'h19 || mem_req !== 1'b0)
      $display("FAIL lw_commit: got pcready=%b rdata=%h req=%b want 1 19 0", PCReady, ReadData, mem_req);
    else passed++;
    MemStrobe = 1'b0;
    step();
    total++; if (PCReady !== 1'b0 || ReadData !== 32'h19) $display("FAIL lw_after: got pcready=%b rdata=%h want 0 19", PCReady, ReadData); else passed++;
    $display("txn lw: ReadData=%h", ReadData);
  endtask

  task automatic test_store();
    PC = 32'h8; mem_ack = 1'b1; mem_rdata = 32'h04A10323; #1;
    step();
    MemStrobe = 1'b1; MemWrite = 1'b1; DataAdr = 32'h66; ByteMask = 4'b0100;
    WriteData = 32'h5A5A5A5A; mem_rdata = 32'hDEADBEEF; #1;
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h64)
      $display("FAIL sb_req: got req=%b we=%b addr=%h want 1 1 64", mem_req, mem_we, mem_addr);
    else passed++;
    total++; if (mem_wmask !== 4'b0100 || mem_wdata !== 32'h5A5A5A5A || PCReady !== 1'b0)
      $display("FAIL sb_data: got mask=%b wdata=%h pcready=%b want 0100 5a5a5a5a 0", mem_wmask, mem_wdata, PCReady);
    else passed++;
    step();
    mem_ack = 1'b0; #1;
    total++; if (PCReady !== 1'b1 || ReadData !== 32'h19 || mem_req !== 1'b0)
      $display("FAIL sb_commit: got pcready=%b rdata=%h req=%b want 1 19 0", PCReady, ReadData, mem_req);
    else passed++;
    MemStrobe = 1'b0; MemWrite = 1'b0;
    step();
    total++; if (PCReady !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8)
      $display("FAIL sb_next_fetch: got pcready=%b req=%b addr=%h want 0 1 8", PCReady, mem_req, mem_addr);
    else passed++;
    $display("txn sb: addr=%h", DataAdr);
  endtask

  task automatic test_timeout();
    PC = 32'hC; mem_ack = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_req !== 1'b1 || bus_err !== 1'b0) $display("FAIL to_wait%0d: got req=%b err=%b want 1 0", i, mem_req, bus_err); else passed++;
      step();
    end
    total++; if (bus_err !== 1'b1 || mem_req !== 1'b0 || PCReady !== 1'b0)
      $display("FAIL to_err: got err=%b req=%b pcready=%b want 1 0 0", bus_err, mem_req, PCReady);
    else passed++;
    mem_ack = 1'b1; mem_rdata = 32'h00000013; #1;
    for (int i = 0; i < 3; i++) step();
    total++; if (bus_err !== 1'b1 || mem_req !== 1'b0 || PCReady !== 1'b0 || Instr !== 32'h04A10323)
      $display("FAIL to_sticky: got err=%b req=%b pcready=%b instr=%h want 1 0 0 04a10323", bus_err, mem_req, PCReady, Instr);
    else passed++;
    $display("txn timeout: bus_err=%b", bus_err);
    do_reset();
    total++; if (bus_err !== 1'b0 || Instr !== 32'h00000013) $display("FAIL to_reset: got err=%b instr=%h want 0 00000013", bus_err, Instr); else passed++;
  endtask

  task automatic test_misaligned();
    PC = 32'h102; mem_ack = 1'b1; #1;
    total++; if (mem_req !== 1'b0) $display("FAIL mis_no_req: got %b want 0", mem_req); else passed++;
    step();
    total++; if (bus_err !== 1'b1 || mem_req !== 1'b0 || Instr !== 32'h00000013)
      $display("FAIL mis_err: got err=%b req=%b instr=%h want 1 0 00000013", bus_err, mem_req, Instr);
    else passed++;
    $display("txn misaligned: PC=%h bus_err=%b", PC, bus_err);
    do_reset();
  endtask

  task automatic test_reset_mid_load();
    PC = 32'h10; mem_ack = 1'b1; mem_rdata = 32'h00012083; #1;
    step();
    mem_ack = 1'b0; MemStrobe = 1'b1; MemWrite = 1'b0; DataAdr = 32'h80; #1;
    step();
    step();
    reset = 1'b1; #1;
    total++; if (mem_req !== 1'b0) $display("FAIL rst_mid_no_req: got %b want 0", mem_req); else passed++;
    step();
    reset = 1'b0; MemStrobe = 1'b0; #1;
    total++; if (Instr !== 32'h00000013 || bus_err !== 1'b0 || PCReady !== 1'b0)
      $display("FAIL rst_mid_state: got instr=%h err=%b pcready=%b want 00000013 0 0", Instr, bus_err, PCReady);
    else passed++;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0)
      $display("FAIL rst_mid_fetch: got req=%b addr=%h we=%b want 1 10 0", mem_req, mem_addr, mem_we);
    else passed++;
    $display("txn reset_mid_load: Instr=%h", Instr);
  endtask

  task automatic test_back_to_back();
    int retired;
    retired = 0;
    do_reset();
    PC = 32'h20; mem_ack = 1'b1; mem_rdata = 32'h00100093; MemStrobe = 1'b0; #1;
    for (int i = 0; i < 20; i++) begin
      if (PCReady === 1'b1) retired++;
      step();
    end
    total++; if (retired !== 10) $display("FAIL b2b_retired: got %0d want 10", retired); else passed++;
`ifdef MEM_SEQ_PERF_EN
    total++; if (instret_cnt !== 32'd10 || cycle_cnt !== 32'd20)
      $display("FAIL perf_counts: got instret=%0d cycle=%0d want 10 20", instret_cnt, cycle_cnt);
    else passed++;
`endif
    $display("txn back_to_back: retired=%0d", retired);
    mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_misaligned();
    test_reset_mid_load();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
